// File: rtl/div_multicycle_pkg.sv
// Shared types and constants for the multicycle divider: FSM state encoding
// and the level-handshake encodings used between the EX stage and the divider.
package div_multicycle_pkg;

  typedef enum logic [1:0] {
    DivFree  = 2'd0,
    DivOn    = 2'd1,
    DivFixup = 2'd2,
    DivEnd   = 2'd3
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic RstEnable         = 1'b1;

endpackage

// File: rtl/div_multicycle_if.sv
// EX-stage <-> divider bundle. The master (EX) drives operands and the request;
// the slave (divider) returns the result, flags and its FSM state for observation.
interface div_multicycle_if
  import div_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
);
  // Level handshake: start_i is raised with stable operands and held until
  // ready_o is seen; the result is held while start_i stays high, and dropping
  // start_i retires it. annul_i cancels an operation still in flight.
  logic               signed_div_i;
  logic               start_i;
  logic               annul_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;
  logic               div_zero_o;
  logic               overflow_o;
  div_state_e         state_o;

  modport master (
    output signed_div_i, start_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o, div_zero_o, overflow_o, state_o
  );

  modport slave (
    input  signed_div_i, start_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o, div_zero_o, overflow_o, state_o
  );

endinterface

// File: rtl/div_multicycle_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when no borrow occurs.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i, so shifted < 2*divisor and the MSB of diff is the borrow.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_multicycle.sv
// Iterative signed/unsigned divider retiring RADIX_BITS quotient bits per cycle,
// with sign fix-up, divide-by-zero and signed-overflow flags.
module div_multicycle
  import div_multicycle_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input logic            clk,
  input logic            rst,
  div_multicycle_if.slave bus
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic               sign1_q, sign2_q, signed_q, ovf_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q, busy_q, div_zero_q, overflow_q;

  logic [RADIX_BITS:0][WIDTH-1:0] rem_chain;
  logic [RADIX_BITS-1:0]          q_bits;
  logic [WIDTH-1:0]               mag1, mag2, quot_fix, rem_fix;

  assign mag1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  assign rem_chain[0] = rem_q;

  for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_chain[g]),
      .bit_i     (dvd_q[WIDTH-1-g]),
      .divisor_i (dvs_q),
      .rem_o     (rem_chain[g+1]),
      .q_o       (q_bits[RADIX_BITS-1-g])
    );
  end

  assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -dvd_q : dvd_q;
  assign rem_fix  = (signed_q && sign1_q) ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state      <= DivFree;
      cnt        <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state      <= DivEnd;
              result_q   <= '0;
              ready_q    <= DivResultReady;
              div_zero_q <= 1'b1;
              overflow_q <= 1'b0;
            end else begin
              dvd_q    <= mag1;
              dvs_q    <= mag2;
              rem_q    <= '0;
              cnt      <= '0;
              sign1_q  <= bus.opdata1_i[WIDTH-1];
              sign2_q  <= bus.opdata2_i[WIDTH-1];
              signed_q <= bus.signed_div_i;
              ovf_q    <= bus.signed_div_i && (bus.opdata1_i == MOST_NEG) &&
                          (bus.opdata2_i == {WIDTH{1'b1}});
              busy_q   <= 1'b1;
              state    <= DivOn;
            end
          end
        end
        DivOn: begin
          if (bus.annul_i) begin
            state  <= DivFree;
            busy_q <= 1'b0;
          end else begin
            rem_q <= rem_chain[RADIX_BITS];
            dvd_q <= {dvd_q[WIDTH-RADIX_BITS-1:0], q_bits};
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state <= DivFixup;
          end
        end
        DivFixup: begin
          busy_q <= 1'b0;
          if (bus.annul_i) begin
            state <= DivFree;
          end else begin
            // Magnitudes already give the natural overflow result (q = MOST_NEG, r = 0).
            result_q   <= {rem_fix, quot_fix};
            overflow_q <= ovf_q;
            div_zero_q <= 1'b0;
            ready_q    <= DivResultReady;
            state      <= DivEnd;
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop) begin
            state      <= DivFree;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.busy_o     = busy_q;
  assign bus.div_zero_o = div_zero_q;
  assign bus.overflow_o = overflow_q;
  assign bus.state_o    = state;

endmodule

// File: doc/div_multicycle.md
Name: div_multicycle

Overview:
- Parametrised iterative integer divider for the EX stage of the 5-stage MIPS pipeline.
- Computes quotient and remainder for signed or unsigned WIDTH-bit operands.
- Retires RADIX_BITS quotient bits per cycle.
- Beyond the current divider: explicit divide-by-zero and signed-overflow flags, a busy indication, and a remainder whose sign always follows the dividend.
- Uses the existing level start/stop handshake with the EX stage.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- RADIX_BITS, 1, quotient bits retired per cycle; 1 or 2; WIDTH divisible by RADIX_BITS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- signed_div_i  in  1  1 = signed (two's complement) divide, 0 = unsigned.
- start_i  in  1  level request; held high by EX until ready_o is seen, then dropped.
- annul_i  in  1  cancel request (pipeline flush).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- result_o  out  2*WIDTH  {remainder, quotient}; remainder in the upper half.
- ready_o  out  1  result_o and the flags are valid.
- busy_o  out  1  an operation is in progress (state BUSY or FIXUP).
- div_zero_o  out  1  divisor was zero; valid with ready_o.
- overflow_o  out  1  signed most-negative / -1; valid with ready_o.

Behaviour:
- Reset:
  - Asynchronous, active-high; applies immediately regardless of clock.
  - State = IDLE; cnt = 0; working registers = 0.
  - result_o = 0, ready_o = 0, busy_o = 0, div_zero_o = 0, overflow_o = 0.
  - Reset mid-operation discards the operation; no result is produced.
- Operand capture: operands and signed_div_i are sampled only on the IDLE accept edge. Later input changes are ignored until the next IDLE.
- States: IDLE, BUSY, FIXUP, DONE.
- IDLE:
  - Outputs: ready_o = 0, result_o = 0.
  - Accept condition: start_i = 1 and annul_i = 0.
  - On accept with divisor = 0: go to DONE. Load result 0, div_zero_o = 1, overflow_o = 0.
  - On accept otherwise:
    - Latch operand magnitudes (two's-complement negate where signed_div_i and sign bit are set).
    - Latch both sign bits and signed_div_i.
    - Load partial remainder = 0 and cnt = 0; go to BUSY.
  - annul_i = 1 while in IDLE: the request is ignored.
- BUSY:
  - Each cycle performs RADIX_BITS restoring-division steps.
  - Each step: shift the next dividend bit into the partial remainder, trial-subtract the divisor, keep the difference if non-negative, and shift the quotient bit in.
  - cnt increments by 1 each cycle.
  - After N = WIDTH/RADIX_BITS cycles, go to FIXUP.
  - Arithmetic uses a WIDTH+1-bit trial subtract; the MSB is the borrow.
- FIXUP (one cycle):
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - overflow_o = signed and dividend = 2^(WIDTH-1) and divisor = all-ones.
  - In the overflow case the natural result is required: quotient = 0x8..0, remainder = 0.
  - Go to DONE.
- DONE:
  - ready_o = 1; result_o and the flags are held stable.
  - When start_i = 0: next state IDLE; ready_o and all flags clear on that edge.
- Latency: accept edge t0, then BUSY cycles t0+1..t0+N, FIXUP at t0+N+1, ready_o first high in cycle t0+N+2.
  - Divide-by-zero: ready_o high in cycle t0+1.
- annul_i:
  - In BUSY or FIXUP: next state IDLE, busy_o drops, ready_o never asserts for that operation.
  - In DONE: no effect; exit still requires start_i = 0.
  - Simultaneous annul_i with the final BUSY cycle: annul wins.
- busy_o is registered; it equals (state == BUSY or FIXUP).
- Back-to-back operations: minimum one IDLE cycle between them (start_i must drop).

Decomposition:
- Shared defines:
  - State encodings DivFree/DivOn/DivFixup/DivEnd.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - RstEnable is redefined to 1'b1 to match the active-high reset.
- Sub-module div_step:
  - Combinational; one restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated RADIX_BITS times in a generate chain.

Test Plan:
- Unsigned, WIDTH=32, RADIX_BITS=1: 100 / 7 -> q=14, r=2, flags 0; ready_o first high 34 cycles after the accept edge.
- Signed -7 / 2 and 7 / -2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; then q=0xFFFFFFFD, r=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, overflow_o=1. Unsigned same operands -> q=0, r=0x80000000, overflow_o=0.
- Divisor 0 (dividend 0x1234) -> ready_o in cycle t0+1, div_zero_o=1, result_o=0. Dropping start_i returns to IDLE with flags 0.
- annul_i pulsed at BUSY cycle 10 -> IDLE next cycle, ready_o stays 0. A following 0xFFFFFFFF / 16 unsigned -> q=0x0FFFFFFF, r=15. Async rst mid-BUSY -> all outputs 0 immediately.
- RADIX_BITS=2, 1000 / 3 -> q=333, r=1; ready_o first high 18 cycles after accept. Random signed/unsigned sweep against a reference model for both RADIX_BITS values.
